// File: rtl/fpu_seq_ctrl.sv
// Issue/sequencing controller for the RV32F execute stage: dispatches one FP op
// to the single-cycle, pipelined or iterative unit and returns a registered writeback.
module fpu_seq_ctrl #(
    parameter int PIPE_LAT     = 3,
    parameter int ITER_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue_valid,
    output logic        o_issue_ready,
    input  logic [1:0]  i_op_class,
    input  logic [4:0]  i_rd,
    input  logic        i_flush,
    input  logic [31:0] i_sc_result,
    input  logic [4:0]  i_sc_flags,
    output logic        o_pipe_start,
    input  logic [31:0] i_pipe_result,
    input  logic [4:0]  i_pipe_flags,
    output logic        o_iter_start,
    output logic        o_iter_kill,
    input  logic        i_iter_done,
    input  logic [31:0] i_iter_result,
    input  logic [4:0]  i_iter_flags,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_flags,
    input  logic        i_fflags_clr,
    output logic [4:0]  o_fflags,
    output logic        o_busy
);

    localparam logic [3:0]  PIPE_LAT_L     = 4'(PIPE_LAT);
    localparam logic [7:0]  ITER_TIMEOUT_L = 8'(ITER_TIMEOUT);
    localparam logic [31:0] CANONICAL_NAN  = 32'h7FC0_0000;
    localparam logic [4:0]  FLAG_NV        = 5'b10000;

    typedef enum logic [1:0] {IDLE, PIPE_WAIT, ITER_WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  pipe_cnt, pipe_cnt_nxt;
    logic [7:0]  wd_cnt, wd_cnt_nxt;
    logic [4:0]  rd_q, rd_nxt;
    logic        accept;
    logic        wb_load;
    logic        wb_pend_q;
    logic [4:0]  wb_rd_nxt;
    logic [31:0] wb_data_nxt;
    logic [4:0]  wb_flags_nxt;

    always_comb begin
        state_nxt     = state;
        pipe_cnt_nxt  = pipe_cnt;
        wd_cnt_nxt    = wd_cnt;
        rd_nxt        = rd_q;
        wb_load       = 1'b0;
        wb_rd_nxt     = rd_q;
        wb_data_nxt   = '0;
        wb_flags_nxt  = '0;
        o_pipe_start  = 1'b0;
        o_iter_start  = 1'b0;
        o_iter_kill   = 1'b0;
        o_issue_ready = (state == IDLE) && !i_flush;
        accept        = i_issue_valid && o_issue_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (i_op_class)
                        2'b00: begin
                            wb_load      = 1'b1;
                            wb_rd_nxt    = i_rd;
                            wb_data_nxt  = i_sc_result;
                            wb_flags_nxt = i_sc_flags;
                        end
                        2'b01: begin
                            o_pipe_start = 1'b1;
                            rd_nxt       = i_rd;
                            pipe_cnt_nxt = PIPE_LAT_L;
                            state_nxt    = PIPE_WAIT;
                        end
                        2'b10: begin
                            o_iter_start = 1'b1;
                            rd_nxt       = i_rd;
                            wd_cnt_nxt   = ITER_TIMEOUT_L;
                            state_nxt    = ITER_WAIT;
                        end
                        default: begin
                            wb_load      = 1'b1;
                            wb_rd_nxt    = i_rd;
                            wb_flags_nxt = FLAG_NV;
                        end
                    endcase
                end
            end
            PIPE_WAIT: begin
                if (i_flush) begin
                    state_nxt = IDLE;
                end else if (pipe_cnt == 4'd1) begin
                    wb_load      = 1'b1;
                    wb_data_nxt  = i_pipe_result;
                    wb_flags_nxt = i_pipe_flags;
                    pipe_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else begin
                    pipe_cnt_nxt = pipe_cnt - 4'd1;
                end
            end
            ITER_WAIT: begin
                // A flush beats a same-cycle done; a done beats a same-cycle watchdog expiry.
                if (i_flush) begin
                    o_iter_kill = 1'b1;
                    state_nxt   = IDLE;
                end else if (i_iter_done) begin
                    wb_load      = 1'b1;
                    wb_data_nxt  = i_iter_result;
                    wb_flags_nxt = i_iter_flags;
                    state_nxt    = IDLE;
                end else if (wd_cnt == 8'd1) begin
                    o_iter_kill  = 1'b1;
                    wb_load      = 1'b1;
                    wb_data_nxt  = CANONICAL_NAN;
                    wb_flags_nxt = FLAG_NV;
                    wd_cnt_nxt   = '0;
                    state_nxt    = IDLE;
                end else begin
                    wd_cnt_nxt = wd_cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            pipe_cnt  <= '0;
            wd_cnt    <= '0;
            rd_q      <= '0;
            wb_pend_q <= 1'b0;
            o_wb_rd   <= '0;
            o_wb_data <= '0;
            o_wb_flags <= '0;
            o_fflags  <= '0;
        end else begin
            state     <= state_nxt;
            pipe_cnt  <= pipe_cnt_nxt;
            wd_cnt    <= wd_cnt_nxt;
            rd_q      <= rd_nxt;
            wb_pend_q <= wb_load;
            if (wb_load) begin
                o_wb_rd    <= wb_rd_nxt;
                o_wb_data  <= wb_data_nxt;
                o_wb_flags <= wb_flags_nxt;
            end
            o_fflags <= (i_fflags_clr ? 5'b0 : o_fflags) | (o_wb_valid ? o_wb_flags : 5'b0);
        end
    end

    // A flush arriving while the writeback is presented still squashes it.
    assign o_wb_valid = wb_pend_q && !i_flush;
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Scoreboard bench for fpu_seq_ctrl: directed ops push expected writebacks,
// a negedge monitor pops and compares every writeback the DUT presents.
module tb_fpu_seq_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_issue_valid;
    logic        o_issue_ready;
    logic [1:0]  i_op_class;
    logic [4:0]  i_rd;
    logic        i_flush;
    logic [31:0] i_sc_result;
    logic [4:0]  i_sc_flags;
    logic        o_pipe_start;
    logic [31:0] i_pipe_result;
    logic [4:0]  i_pipe_flags;
    logic        o_iter_start;
    logic        o_iter_kill;
    logic        i_iter_done;
    logic [31:0] i_iter_result;
    logic [4:0]  i_iter_flags;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_flags;
    logic        i_fflags_clr;
    logic [4:0]  o_fflags;
    logic        o_busy;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } wb_t;

    wb_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    fpu_seq_ctrl #(.PIPE_LAT(3), .ITER_TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
        .i_op_class(i_op_class), .i_rd(i_rd), .i_flush(i_flush),
        .i_sc_result(i_sc_result), .i_sc_flags(i_sc_flags),
        .o_pipe_start(o_pipe_start), .i_pipe_result(i_pipe_result), .i_pipe_flags(i_pipe_flags),
        .o_iter_start(o_iter_start), .o_iter_kill(o_iter_kill), .i_iter_done(i_iter_done),
        .i_iter_result(i_iter_result), .i_iter_flags(i_iter_flags),
        .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_wb_flags(o_wb_flags),
        .i_fflags_clr(i_fflags_clr), .o_fflags(o_fflags), .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                                 input logic [31:0] res, input logic [4:0] fl);
        i_issue_valid = v;
        i_op_class    = cls;
        i_rd          = rd;
        i_sc_result   = res;
        i_sc_flags    = fl;
    endtask

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sampleEdge();
        @(negedge i_clk);
    endtask

    task automatic expectWb(input logic [4:0] rd, input logic [31:0] data, input logic [4:0] fl);
        wb_t e;
        e.rd = rd;
        e.data = data;
        e.flags = fl;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented writeback must match the oldest expectation.
    always @(negedge i_clk) begin
        if (i_rst_n && o_wb_valid) begin
            wb_t got;
            got = {o_wb_rd, o_wb_data, o_wb_flags};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL wb_unexpected: got rd=%0d data=%h flags=%b expected no writeback",
                         o_wb_rd, o_wb_data, o_wb_flags);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("[TB] FAIL wb_compare: got rd=%0d data=%h flags=%b expected rd=%0d data=%h flags=%b",
                             got.rd, got.data, got.flags, e.rd, e.data, e.flags);
                end
            end
        end
    end

    initial begin
        logic [31:0] sc_data [3];
        int kill_cycle;
        sc_data[0] = 32'h3F80_0000;
        sc_data[1] = 32'h4000_0000;
        sc_data[2] = 32'h0000_0000;

        i_rst_n = 1'b0;
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        i_flush = 1'b0; i_pipe_result = '0; i_pipe_flags = '0;
        i_iter_done = 1'b0; i_iter_result = '0; i_iter_flags = '0; i_fflags_clr = 1'b0;
        #3;
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_wb_valid", o_wb_valid, 0);
        checkOutput("rst_fflags", o_fflags, 0);
        checkOutput("rst_ready", o_issue_ready, 1);
        sampleEdge();
        i_rst_n = 1'b1;
        nextCycle();

        // Back-to-back single-cycle ops
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b00, 5'(i + 1), sc_data[i], 5'b0);
            expectWb(5'(i + 1), sc_data[i], 5'b0);
            sampleEdge();
            checkOutput("b2b_ready", o_issue_ready, 1);
            if (i > 0) checkOutput("b2b_wb_valid", o_wb_valid, 1);
            nextCycle();
        end
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        sampleEdge();
        checkOutput("b2b_wb_valid_last", o_wb_valid, 1);
        nextCycle();
        sampleEdge();
        checkOutput("b2b_wb_done", o_wb_valid, 0);
        nextCycle();

        // Pipelined op, result sampled exactly PIPE_LAT cycles after accept
        applyStimulus(1'b1, 2'b01, 5'd7, 32'hFFFF_FFFF, 5'h1F);
        expectWb(5'd7, 32'h4040_0000, 5'b00001);
        sampleEdge();
        checkOutput("pipe_start", o_pipe_start, 1);
        checkOutput("pipe_no_iter_start", o_iter_start, 0);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        for (int c = 1; c <= 3; c++) begin
            i_pipe_result = (c == 3) ? 32'h4040_0000 : 32'hBAD0_0000;
            i_pipe_flags  = (c == 3) ? 5'b00001 : 5'b11110;
            sampleEdge();
            checkOutput("pipe_ready_low", o_issue_ready, 0);
            nextCycle();
        end
        i_pipe_result = 32'hBAD1_0000; i_pipe_flags = 5'b11110;
        sampleEdge();
        checkOutput("pipe_ready_back", o_issue_ready, 1);
        nextCycle();
        sampleEdge();
        checkOutput("pipe_fflags", o_fflags, 5'b00001);
        nextCycle();

        // Iterative op with no done: watchdog expires after 8 cycles
        applyStimulus(1'b1, 2'b10, 5'd9, 32'h0, 5'h0);
        expectWb(5'd9, 32'h7FC0_0000, 5'b10000);
        sampleEdge();
        checkOutput("iter_start", o_iter_start, 1);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        kill_cycle = 0;
        for (int c = 1; c <= 20 && kill_cycle == 0; c++) begin
            sampleEdge();
            if (o_iter_kill) kill_cycle = c;
            nextCycle();
        end
        checkOutput("wd_kill_cycle", kill_cycle, 8);
        sampleEdge();
        checkOutput("wd_kill_once", o_iter_kill, 0);
        nextCycle();
        sampleEdge();
        checkOutput("wd_fflags", o_fflags, 5'b10001);
        nextCycle();

        // Iterative done coinciding with fflags clear: new DZ survives
        applyStimulus(1'b1, 2'b10, 5'd4, 32'h0, 5'h0);
        expectWb(5'd4, 32'h40A0_0000, 5'b01000);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        nextCycle();
        nextCycle();
        i_iter_done = 1'b1; i_iter_result = 32'h40A0_0000; i_iter_flags = 5'b01000;
        sampleEdge();
        checkOutput("clr_prior_fflags", o_fflags, 5'b10001);
        nextCycle();
        i_iter_done = 1'b0; i_fflags_clr = 1'b1;
        sampleEdge();
        nextCycle();
        i_fflags_clr = 1'b0;
        sampleEdge();
        checkOutput("clr_wb_fflags", o_fflags, 5'b01000);
        nextCycle();

        // Reserved class writes back zero with NV
        applyStimulus(1'b1, 2'b11, 5'd3, 32'hDEAD_BEEF, 5'b00011);
        expectWb(5'd3, 32'h0, 5'b10000);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        sampleEdge();
        checkOutput("rsv_busy", o_busy, 0);
        nextCycle();
        sampleEdge();
        checkOutput("rsv_fflags", o_fflags, 5'b11000);
        nextCycle();

        // Done in the watchdog expiry cycle wins over the kill
        applyStimulus(1'b1, 2'b10, 5'd6, 32'h0, 5'h0);
        expectWb(5'd6, 32'h3FC0_0000, 5'b00100);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        repeat (7) nextCycle();
        i_iter_done = 1'b1; i_iter_result = 32'h3FC0_0000; i_iter_flags = 5'b00100;
        sampleEdge();
        checkOutput("race_no_kill", o_iter_kill, 0);
        nextCycle();
        i_iter_done = 1'b0;
        sampleEdge();
        checkOutput("race_kill_after", o_iter_kill, 0);
        nextCycle();
        sampleEdge();
        checkOutput("race_fflags", o_fflags, 5'b11100);
        nextCycle();

        // Flush in ITER_WAIT, later stray done must not write back
        applyStimulus(1'b1, 2'b10, 5'd12, 32'h0, 5'h0);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        nextCycle();
        i_flush = 1'b1;
        sampleEdge();
        checkOutput("flush_iter_kill", o_iter_kill, 1);
        checkOutput("flush_ready_low", o_issue_ready, 0);
        nextCycle();
        i_flush = 1'b0;
        sampleEdge();
        checkOutput("flush_iter_idle", o_busy, 0);
        checkOutput("flush_kill_once", o_iter_kill, 0);
        nextCycle();
        i_iter_done = 1'b1; i_iter_result = 32'h1234_5678; i_iter_flags = 5'b00010;
        sampleEdge();
        checkOutput("stray_done_kill", o_iter_kill, 0);
        nextCycle();
        i_iter_done = 1'b0;
        nextCycle();
        sampleEdge();
        checkOutput("flush_iter_fflags", o_fflags, 5'b11100);
        nextCycle();

        // Flush squashes a single-cycle wb and blocks the op presented with it
        applyStimulus(1'b1, 2'b00, 5'd5, 32'h1234_0000, 5'b00010);
        nextCycle();
        applyStimulus(1'b1, 2'b00, 5'd6, 32'h5678_0000, 5'b00010);
        i_flush = 1'b1;
        sampleEdge();
        checkOutput("flush_sc_wb", o_wb_valid, 0);
        checkOutput("flush_sc_ready", o_issue_ready, 0);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        i_flush = 1'b0;
        sampleEdge();
        checkOutput("flush_sc_blocked", o_wb_valid, 0);
        nextCycle();
        sampleEdge();
        checkOutput("flush_sc_fflags", o_fflags, 5'b11100);
        nextCycle();

        // Reset asserted asynchronously in the middle of ITER_WAIT
        applyStimulus(1'b1, 2'b10, 5'd8, 32'h0, 5'h0);
        nextCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 5'h0);
        nextCycle();
        #1;
        checkOutput("pre_rst_busy", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", o_busy, 0);
        checkOutput("async_rst_wb_valid", o_wb_valid, 0);
        checkOutput("async_rst_fflags", o_fflags, 0);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        sampleEdge();
        checkOutput("post_rst_ready", o_issue_ready, 1);
        nextCycle();
        repeat (3) nextCycle();

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
- Issue/sequencing controller for the floating-point execute stage of the RV32F pipeline.
- Accepts one FP op at a time from the decode/EX boundary and dispatches it to one of three execution resources:
  - single-cycle combinational units (class, move, compare, sign-inject);
  - a fixed-latency pipelined add/mul unit;
  - an iterative div/sqrt unit.
- Returns a registered writeback (data, rd tag, exception flags), maintains the accrued fflags CSR bits, and drives pipeline backpressure.

Parameters:
- PIPE_LAT, 3, cycles from o_pipe_start to valid i_pipe_result/i_pipe_flags (legal range 1..15).
- ITER_TIMEOUT, 64, max cycles waited for i_iter_done before the watchdog forces completion (legal range 2..255).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_issue_valid  in  1  op presented
- o_issue_ready  out  1  controller can accept op this cycle
- i_op_class  in  2  00 single-cycle, 01 pipelined, 10 iterative, 11 reserved
- i_rd  in  5  destination register tag
- i_flush  in  1  squash in-flight op (branch mispredict / trap)
- i_sc_result  in  32  single-cycle unit result, valid in the accept cycle
- i_sc_flags  in  5  single-cycle unit flags {NV,DZ,OF,UF,NX}
- o_pipe_start  out  1  launch pipelined unit
- i_pipe_result  in  32  pipelined unit result
- i_pipe_flags  in  5  pipelined unit flags
- o_iter_start  out  1  launch iterative unit
- o_iter_kill  out  1  abort iterative unit
- i_iter_done  in  1  iterative result valid (1-cycle pulse)
- i_iter_result  in  32  iterative result
- i_iter_flags  in  5  iterative flags
- o_wb_valid  out  1  writeback valid (1-cycle pulse)
- o_wb_rd  out  5  writeback tag
- o_wb_data  out  32  writeback data
- o_wb_flags  out  5  flags of this op
- i_fflags_clr  in  1  clear accrued flags (CSR write)
- o_fflags  out  5  accrued exception flags
- o_busy  out  1  op in flight (state != IDLE)

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, all counters 0. Every output is 0 except o_issue_ready, which follows IDLE.
- FSM states: IDLE, PIPE_WAIT, ITER_WAIT.
- o_issue_ready = (state==IDLE) & ~i_flush. Accept = i_issue_valid & o_issue_ready.
- Accept in IDLE:
  - Class 00 or 11: capture i_sc_result/i_sc_flags/i_rd. o_wb_valid is asserted at T+1. State stays IDLE. Class 11 is written back with data 0 and flags 5'b10000 (NV).
  - Class 01: o_pipe_start=1 combinationally in cycle T. Latch rd and load counter=PIPE_LAT. Go to PIPE_WAIT.
  - Class 10: o_iter_start=1 combinationally in cycle T. Latch rd and load watchdog=ITER_TIMEOUT. Go to ITER_WAIT.
- PIPE_WAIT:
  - Decrement the counter each cycle.
  - In cycle T+PIPE_LAT (counter==1), sample i_pipe_result/flags and go to IDLE.
  - o_wb_valid is asserted at T+PIPE_LAT+1.
- ITER_WAIT:
  - On i_iter_done, sample the result/flags and go to IDLE; wb follows next cycle.
  - Otherwise decrement the watchdog. When it reaches 0 with no done, pulse o_iter_kill for one cycle, write back data 32'h7FC00000 with flags 5'b10000, and go to IDLE.
  - i_iter_done in the same cycle as watchdog expiry: done wins, no kill.
- Writeback: o_wb_* are registered. o_wb_valid is a single-cycle pulse. o_wb_data/rd/flags hold their last values when not valid.
- A new accept is permitted in the same cycle that o_wb_valid is high (back-to-back single-cycle ops produce wb every cycle).
- Flush:
  - Any state goes to IDLE next cycle and suppresses the pending/next wb. This includes a single-cycle op accepted in the previous cycle, whose T+1 wb is squashed.
  - In ITER_WAIT, flush pulses o_iter_kill for one cycle.
  - i_pipe_result arriving after a flush is ignored.
  - An op presented in the flush cycle is not accepted.
- Accrued flags: o_fflags <= (i_fflags_clr ? 0 : o_fflags) | (o_wb_valid ? o_wb_flags : 0). When clear and wb coincide, the new flags survive.
- Unexpected i_iter_done outside ITER_WAIT is ignored. o_pipe_start and o_iter_start are never high simultaneously.

Test Plan:
- Reset mid-ITER_WAIT: assert i_rst_n=0 asynchronously → o_busy=0, o_wb_valid=0, o_fflags=0 immediately; o_issue_ready=1 after release.
- Single-cycle back-to-back: three class-00 ops rd=1,2,3, data 0x3F800000/0x40000000/0x0 → o_wb_valid high 3 consecutive cycles, rd 1,2,3 in order, o_issue_ready never drops.
- Pipelined, PIPE_LAT=3: accept at cycle 10, rd=7, unit returns 0x40400000 flags NX at cycle 13 → wb at cycle 14 with rd=7, o_fflags=5'b00001; o_issue_ready low cycles 11–13.
- Iterative watchdog, ITER_TIMEOUT=8: start, never assert done → o_iter_kill pulse once, wb data 0x7FC00000 flags 5'b10000, o_fflags NV set.
- Flush in ITER_WAIT at cycle 5, then done pulse at cycle 7 → o_iter_kill at cycle 5, no wb ever, o_fflags unchanged.
- i_fflags_clr coinciding with wb flags DZ, prior o_fflags=5'b10001 → o_fflags=5'b01000 next cycle.
